// File: rtl/pc_stall_scheduler_pkg.sv
// Shared definitions for the PC stall scheduler: FSM state encoding and
// default widths used by the scheduler, its arbiter and its bus interface.
package pineapple_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 10;
    localparam int STAT_W_DEF  = 16;

endpackage

// File: rtl/pc_stall_scheduler_if.sv
// Bus between the stall sources and the scheduler: per-requester request and
// delay going in, grant/done/PC-enable/statistics coming back.
interface pc_stall_scheduler_if
    import pineapple_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STAT_W  = STAT_W_DEF
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] reqDelay;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     pcEn;
    logic                     busy;
    logic [STAT_W-1:0]        stallCycles;

    // Stall sources side
    modport master (
        output req, reqDelay,
        input  grant, done, pcEn, busy, stallCycles
    );

    // Scheduler side
    modport slave (
        input  req, reqDelay,
        output grant, done, pcEn, busy, stallCycles
    );
endinterface

// File: rtl/pc_stall_scheduler_rr_arbiter.sv
// Round-robin picker: searches upward from the last winner + 1 with wrap,
// so the most recently served requester has lowest priority next time.
module rr_arbiter
    import pineapple_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       update,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               cand;

    // Pick the first requesting index after the pointer, wrapping at NUM_REQ
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found            = 1'b1;
                winner[cand_idx] = 1'b1;
                winner_idx       = cand_idx;
            end
        end
    end

    // Pointer remembers the last winner; reset value gives requester 0 first turn
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) ptr <= IDX_W'(NUM_REQ - 1);
        else if (update) ptr <= winner_idx;
    end
endmodule

// File: rtl/pc_stall_scheduler.sv
// PC stall scheduler: grants one stall requester at a time, holds pcEn low
// for the requested number of cycles, then keeps the PC running for at least
// two cycles (RELEASE + IDLE) before the next stall can start.
module pc_stall_scheduler
    import pineapple_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STAT_W  = STAT_W_DEF
) (
    input  logic                clk,
    input  logic                rstN,
    pc_stall_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   sel_delay;
    logic [CNT_W-1:0]   load_val;
    logic [NUM_REQ-1:0] winner;
    logic [IDX_W-1:0]   winner_idx;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic [NUM_REQ-1:0] done_q, done_nxt;
    logic               pcEn_q, pcEn_nxt;
    logic               busy_q, busy_nxt;
    logic               update;
    logic               cnt_last;
    logic [STAT_W-1:0]  stat_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A grant happens only from IDLE; RELEASE never samples req
    assign update   = (state == IDLE) && (|bus.req);
    assign cnt_last = (cnt == CNT_W'(1));

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk        (clk),
        .rstN       (rstN),
        .req        (bus.req),
        .update     (update),
        .winner     (winner),
        .winner_idx (winner_idx)
    );

    // Select the winner's delay; zero is stretched to a single stall cycle
    always_comb begin
        sel_delay = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == winner_idx) sel_delay = bus.reqDelay[i*CNT_W +: CNT_W];
        end
        load_val = (sel_delay == '0) ? CNT_W'(1) : sel_delay;
    end

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bus.req) state_nxt = STALL;
            STALL:   if (cnt_last) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        grant_nxt = grant_q;
        done_nxt  = '0;
        pcEn_nxt  = pcEn_q;
        busy_nxt  = busy_q;
        case (state)
            IDLE: begin
                if (update) begin
                    grant_nxt = winner;
                    pcEn_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end else begin
                    grant_nxt = '0;
                    pcEn_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            STALL: begin
                if (cnt_last) begin
                    grant_nxt = '0;
                    pcEn_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = grant_q;
                end
            end
            default: begin
                grant_nxt = '0;
                pcEn_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Output registers; reset discards any stall in progress without a done
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            grant_q <= '0;
            done_q  <= '0;
            pcEn_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            grant_q <= grant_nxt;
            done_q  <= done_nxt;
            pcEn_q  <= pcEn_nxt;
            busy_q  <= busy_nxt;
        end
    end

    // Down-counter: loaded at the grant edge, decremented through STALL
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                cnt <= '0;
        else if (update)          cnt <= load_val;
        else if (state == STALL)  cnt <= cnt - 1'b1;
    end

    // Saturating count of edges seen with the PC held
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)        stat_q <= '0;
        else if (!pcEn_q) stat_q <= sat_inc(stat_q);
    end

    assign bus.grant       = grant_q;
    assign bus.done        = done_q;
    assign bus.pcEn        = pcEn_q;
    assign bus.busy        = busy_q;
    assign bus.stallCycles = stat_q;
endmodule
